controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
Multicycle MIPS-subset main control unit; the producer side of the ALU interface. It generates the 3-bit ULAControl and operand selects for the ALU and consumes its Z flag to resolve branches. It sequences datapath enables (PC, IR, memory, register file) through a Moore FSM, with wait states on a memory ready handshake. It sits between the instruction register (op/funct) and the shared-memory multicycle datapath.

Parameters:
STATE_W, 4, width of the state register and the dbg_estado port.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  instruction[31:26]
funct  in  6  instruction[5:0]
Z  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
ULAControl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt, 111 invalid (ALU returns 0)
ULASrcA  out  1  0 = PC, 1 = A register
ULASrcB  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
PCEn  out  1  PC write enable = PCWrite | (Branch & branch condition)
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegWrite  out  1  register file write
RegDst  out  1  0 = rt, 1 = rd
MemtoReg  out  1  0 = ALUOut, 1 = Data
illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
dbg_estado  out  STATE_W  current state encoding

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- R-type funct mapping: 100000 add→000, 100010 sub→001, 100100 and→010, 100101 or→011, 101010 slt→101. Any other funct → 111.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Encodings 12–15 are unreachable; if entered, go to FETCH next cycle.
- Transitions:
  - FETCH→DECODE when mem_ready, else stay.
  - DECODE → MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEX (addi), JUMP (j); any other opcode → FETCH with illegal_op=1.
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB on mem_ready, else stay.
  - MEMWRITE→FETCH on mem_ready, else stay.
  - EXECUTE→ALUWB. ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP → FETCH.
- Outputs are Moore, decoded from state. Every output not listed for a state is 0, with ULAControl 000 by default.
  - FETCH: ULASrcB=01, add, IRWrite=PCWrite=mem_ready.
  - DECODE: ULASrcB=11, add (precomputes branch target).
  - MEMADR, ADDIEX: ULASrcA=1, ULASrcB=10, add.
  - MEMREAD: IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWRITE: IorD=1, MemWrite=1, held for the whole wait.
  - EXECUTE: ULASrcA=1, ULAControl from funct.
  - ALUWB: RegWrite=1, RegDst=1. ADDIWB: RegWrite=1.
  - BRANCH: ULASrcA=1, sub, PCSrc=01, PCEn=Z (combinational from Z).
  - JUMP: PCSrc=10, PCEn=1.
- Latency with mem_ready held at 1: j 3 cycles, beq 3, R 4, addi 4, sw 4, lw 5.
- Reset: while rst_n=0, state=FETCH and every enable (PCEn, IRWrite, MemWrite, RegWrite) is forced to 0. ULAControl=000, illegal_op=0, dbg_estado=0. After release, the FETCH outputs apply from the first clock. Reset mid-instruction abandons the instruction with no write strobe.
- Invalid funct in EXECUTE still reaches ALUWB and writes 0 to rd, since the ALU returns 0 for 111.

Optional Feature:
CONTROLE_BNE_EN: when defined, opcode 000101 (bne) is decoded to BRANCH with the condition inverted, so PCEn=~Z. A registered flag captured in DECODE distinguishes beq from bne. When undefined, 000101 is illegal: illegal_op pulses and the FSM returns to FETCH.

Decomposition:
- Package controle_pkg holds:
  - the state enum (explicit encodings above);
  - opcode and funct localparams;
  - ULAControl codes (ULA_ADD, ULA_SUB, ULA_AND, ULA_OR, ULA_SLT, ULA_INV);
  - ULASrcB and PCSrc select codes.
- Sub-module decodificador_ula: combinational; inputs funct and a 2-bit ULAOp (00 add, 01 sub, 10 funct); output ULAControl.

Test Plan:
1. Reset release, op=100011 lw, mem_ready=1 → states 0,1,2,3,4,0. MemWB cycle: RegWrite=1, MemtoReg=1. ULAControl=000 in MEMADR.
2. R-type funct=101010 → EXECUTE ULAControl=101, ULASrcA=1, ULASrcB=00. ALUWB: RegWrite=1, RegDst=1. Instruction takes 4 cycles.
3. beq with Z=1, then beq with Z=0 → BRANCH ULAControl=001, PCSrc=01. PCEn=1 in the first case, 0 in the second.
4. sw with mem_ready low for 3 cycles in MEMWRITE → MemWrite=1, IorD=1 held for 4 cycles. Transition to FETCH only on mem_ready=1. No RegWrite at any point.
5. op=111111 → illegal_op=1 for exactly one cycle in DECODE, next state FETCH. With CONTROLE_BNE_EN defined, op=000101 with Z=0 → PCEn=1.
6. rst_n asserted in MEMWB → asynchronous return to state 0, RegWrite drops immediately. No IRWrite until rst_n is high and mem_ready=1.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle control unit: state encodings, opcodes, ALU codes, mux selects.
// No logic; purely types and constants.
// No flow control; consumed by controle_multiciclo and decodificador_ula.
package controle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } estado_t;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct field (instruction[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_AND = 3'b010;
    localparam logic [2:0] ULA_OR  = 3'b011;
    localparam logic [2:0] ULA_SLT = 3'b101;
    localparam logic [2:0] ULA_INV = 3'b111;

    // ULAOp: what the main FSM asks of the ALU decoder
    localparam logic [1:0] ULAOP_ADD   = 2'b00;
    localparam logic [1:0] ULAOP_SUB   = 2'b01;
    localparam logic [1:0] ULAOP_FUNCT = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_RESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/decodificador_ula.sv
// ALU decoder: maps ULAOp and funct to the 3-bit ULAControl code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module decodificador_ula
    import controle_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] ULAOp,
    output logic [2:0] ULAControl
);

    // Fixed add/sub for address and branch arithmetic, funct decode for R-type
    always_comb begin
        ULAControl = ULA_ADD;
        unique case (ULAOp)
            ULAOP_ADD: ULAControl = ULA_ADD;
            ULAOP_SUB: ULAControl = ULA_SUB;
            ULAOP_FUNCT: begin
                unique case (funct)
                    FN_ADD:  ULAControl = ULA_ADD;
                    FN_SUB:  ULAControl = ULA_SUB;
                    FN_AND:  ULAControl = ULA_AND;
                    FN_OR:   ULAControl = ULA_OR;
                    FN_SLT:  ULAControl = ULA_SLT;
                    default: ULAControl = ULA_INV;
                endcase
            end
            default: ULAControl = ULA_INV;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-subset main control: Moore FSM sequencing PC/IR/memory/regfile enables and ALU selects.
// Latency (mem_ready=1): j/beq 3, R/addi/sw 4, lw 5 cycles; CONTROLE_BNE_EN adds bne (PCEn=~Z).
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; enables forced low while rst_n=0.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               Z,
    input  logic               mem_ready,
    output logic [2:0]         ULAControl,
    output logic               ULASrcA,
    output logic [1:0]         ULASrcB,
    output logic [1:0]         PCSrc,
    output logic               PCEn,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_estado
);

    estado_t    state_q, state_d;
    logic [1:0] ula_op;
    logic       pc_write, branch, br_cond;
    logic       ir_write_raw, mem_write_raw, reg_write_raw;

    // State register; reset lands in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

`ifdef CONTROLE_BNE_EN
    logic bne_q, bne_d;
    assign bne_d = (state_q == S_DECODE) ? (op == OP_BNE) : bne_q;

    // Remember whether the branch being resolved is bne, captured while decoding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bne_q <= 1'b0;
        else        bne_q <= bne_d;
    end
    assign br_cond = bne_q ? ~Z : Z;
`else
    assign br_cond = Z;
`endif

    // Next-state and Moore output decode
    always_comb begin
        state_d       = S_FETCH;
        ula_op        = ULAOP_ADD;
        ULASrcA       = 1'b0;
        ULASrcB       = SRCB_REG;
        PCSrc         = PCSRC_RESULT;
        pc_write      = 1'b0;
        branch        = 1'b0;
        IorD          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ULASrcB      = SRCB_FOUR;
                ir_write_raw = mem_ready;
                pc_write     = mem_ready;
                state_d      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is computed here so BRANCH only needs the compare
                ULASrcB = SRCB_IMMSH2;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef CONTROLE_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ULASrcA = 1'b1;
                ULASrcB = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                IorD    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                MemtoReg      = 1'b1;
            end
            S_MEMWRITE: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                ULASrcA = 1'b1;
                ula_op  = ULAOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                RegDst        = 1'b1;
            end
            S_BRANCH: begin
                ULASrcA = 1'b1;
                ula_op  = ULAOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                ULASrcA = 1'b1;
                ULASrcB = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
            end
            S_JUMP: begin
                PCSrc    = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: state_d = S_FETCH;  // unused encodings recover to FETCH
        endcase
    end

    decodificador_ula u_dec (
        .funct      (funct),
        .ULAOp      (ula_op),
        .ULAControl (ULAControl)
    );

    // Enables are gated by reset so nothing writes while rst_n is held low
    assign PCEn       = rst_n & (pc_write | (branch & br_cond));
    assign IRWrite    = rst_n & ir_write_raw;
    assign MemWrite   = rst_n & mem_write_raw;
    assign RegWrite   = rst_n & reg_write_raw;
    assign dbg_estado = STATE_W'(state_q);

endmodule

// File: tb/tb_controle_multiciclo.sv
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       Z, mem_ready;
    logic [2:0] ULAControl;
    logic       ULASrcA;
    logic [1:0] ULASrcB, PCSrc;
    logic       PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, illegal_op;
    logic [3:0] dbg_estado;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    controle_multiciclo #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .Z          (Z),
        .mem_ready  (mem_ready),
        .ULAControl (ULAControl),
        .ULASrcA    (ULASrcA),
        .ULASrcB    (ULASrcB),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .illegal_op (illegal_op),
        .dbg_estado (dbg_estado)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock, settle 1 time unit past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; op = 6'b100011; funct = 6'b0; Z = 1'b0; mem_ready = 1'b1;
        #1;
        // Reset state
        chk("rst_state",   dbg_estado, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_pcen",    PCEn, 0);
        chk("rst_ulactl",  ULAControl, 0);
        chk("rst_illegal", illegal_op, 0);
        tick(); tick();
        rst_n = 1'b1; #1;
        // FETCH outputs apply as soon as reset is released
        chk("fetch_irwrite", IRWrite, 1);
        chk("fetch_pcen",    PCEn, 1);
        chk("fetch_srcb",    ULASrcB, 2'b01);

        // lw: 0,1,2,3,4,0
        tick(); chk("lw_s1", dbg_estado, 1); chk("dec_srcb", ULASrcB, 2'b11);
        tick(); chk("lw_s2", dbg_estado, 2); chk("memadr_ula", ULAControl, 3'b000);
                chk("memadr_srca", ULASrcA, 1); chk("memadr_srcb", ULASrcB, 2'b10);
        tick(); chk("lw_s3", dbg_estado, 3); chk("memread_iord", IorD, 1);
        tick(); chk("lw_s4", dbg_estado, 4); chk("memwb_regwrite", RegWrite, 1);
                chk("memwb_memtoreg", MemtoReg, 1);
        tick(); chk("lw_s0", dbg_estado, 0);

        // R-type slt: 4 cycles
        op = 6'b000000; funct = 6'b101010;
        tick(); chk("r_s1", dbg_estado, 1);
        tick(); chk("r_s6", dbg_estado, 6); chk("exec_ula", ULAControl, 3'b101);
                chk("exec_srca", ULASrcA, 1); chk("exec_srcb", ULASrcB, 2'b00);
        tick(); chk("r_s7", dbg_estado, 7); chk("aluwb_regwrite", RegWrite, 1);
                chk("aluwb_regdst", RegDst, 1);
        tick(); chk("r_s0", dbg_estado, 0);

        // R-type with unsupported funct still writes back
        funct = 6'b000000;
        tick(); tick(); chk("rinv_ula", ULAControl, 3'b111);
        tick(); chk("rinv_s7", dbg_estado, 7); chk("rinv_regwrite", RegWrite, 1);
        tick();

        // beq taken
        op = 6'b000100; Z = 1'b1;
        tick(); tick(); chk("beq_s8", dbg_estado, 8); chk("beq_ula", ULAControl, 3'b001);
                chk("beq_pcsrc", PCSrc, 2'b01); chk("beq_taken_pcen", PCEn, 1);
        tick(); chk("beq_s0", dbg_estado, 0);
        // beq not taken
        Z = 1'b0;
        tick(); tick(); chk("beq2_s8", dbg_estado, 8); chk("beq_nt_pcen", PCEn, 0);
        tick();

        // sw with 3 wait cycles in MEMWRITE
        op = 6'b101011;
        tick(); tick(); mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) mem_ready = 1'b0;
            tick();
            if (i == 3) begin mem_ready = 1'b1; #1; end
            chk("sw_state", dbg_estado, 5);
            chk("sw_memwrite", MemWrite, 1);
            chk("sw_iord", IorD, 1);
            chk("sw_regwrite", RegWrite, 0);
        end
        tick(); chk("sw_s0", dbg_estado, 0);

        // FETCH waits on mem_ready
        mem_ready = 1'b0; #1;
        chk("fetch_wait_irw", IRWrite, 0);
        tick(); chk("fetch_wait_s0", dbg_estado, 0);
        mem_ready = 1'b1;

        // addi
        op = 6'b001000;
        tick(); tick(); chk("addi_s9", dbg_estado, 9); chk("addiex_srcb", ULASrcB, 2'b10);
        tick(); chk("addi_s10", dbg_estado, 10); chk("addiwb_regwrite", RegWrite, 1);
                chk("addiwb_regdst", RegDst, 0);
        tick(); chk("addi_s0", dbg_estado, 0);

        // j
        op = 6'b000010;
        tick(); tick(); chk("j_s11", dbg_estado, 11); chk("j_pcsrc", PCSrc, 2'b10);
                chk("j_pcen", PCEn, 1);
        tick(); chk("j_s0", dbg_estado, 0);

        // illegal opcode
        op = 6'b111111;
        tick(); chk("ill_s1", dbg_estado, 1); chk("ill_pulse", illegal_op, 1);
        tick(); chk("ill_s0", dbg_estado, 0); chk("ill_clear", illegal_op, 0);

        // opcode 000101
        op = 6'b000101; Z = 1'b0;
        tick();
`ifdef CONTROLE_BNE_EN
        chk("bne_legal", illegal_op, 0);
        tick(); chk("bne_s8", dbg_estado, 8); chk("bne_nt_z0_pcen", PCEn, 1);
        Z = 1'b1; #1; chk("bne_z1_pcen", PCEn, 0);
        tick();
`else
        chk("bne_illegal", illegal_op, 1);
        tick(); chk("bne_s0", dbg_estado, 0);
`endif

        // reset during MEMWB
        op = 6'b100011; Z = 1'b0;
        tick(); tick(); tick(); tick();
        chk("rstmid_s4", dbg_estado, 4); chk("rstmid_rw_before", RegWrite, 1);
        #2 rst_n = 1'b0; #1;
        chk("rstmid_s0", dbg_estado, 0);
        chk("rstmid_regwrite", RegWrite, 0);
        chk("rstmid_irwrite", IRWrite, 0);
        tick();
        mem_ready = 1'b0; rst_n = 1'b1; #1;
        chk("rel_no_ready_irw", IRWrite, 0);
        mem_ready = 1'b1; #1;
        chk("rel_ready_irw", IRWrite, 1);
        tick(); chk("rel_s1", dbg_estado, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
